// File: rtl/div_seq_64_32.sv
// ---------------------------------------------------------------------------
// div_seq_64_32 : sequential radix-2 restoring divider, N-bit / M-bit.
// Produces an M-bit quotient and M-bit remainder, one quotient bit per cycle.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and a producer keeps its data
// stable until the transfer. in_ready is high only when idle, and out_valid
// is high only while a result is being held.
// Optional build macro DIV_SELFCHECK_EN: rebuilds quotient*divisor+remainder
// in DONE and raises check_err if it differs from the latched dividend.
// ---------------------------------------------------------------------------
module div_seq_64_32 #(
   parameter int M = 32,
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] quotient,
   output logic [M-1:0] remainder,
   output logic         div_by_zero,
   output logic         overflow,
   output logic         check_err
);

   localparam int CW = $clog2(M);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         r_state;
   logic           r_in_ready;
   logic           r_out_valid;
   logic [M-1:0]   r_divisor;
   logic [M-1:0]   r_part_rem;
   logic [M-1:0]   r_shift_q;
   logic [CW-1:0]  r_cnt;
   logic [M-1:0]   r_quotient;
   logic [M-1:0]   r_remainder;
   logic           r_dbz;
   logic           r_ovf;

   logic [M:0]     w_trial;
   logic [M:0]     w_diff;
   logic           w_ge;
   logic [M-1:0]   w_next_rem;
   logic [M-1:0]   w_next_q;

   // One restoring step: bring down the next dividend bit, subtract if it fits.
   // R < divisor always holds, so the M+1-bit trial never overflows.
   always_comb begin
      w_trial    = {r_part_rem, r_shift_q[M-1]};
      w_diff     = w_trial - {1'b0, r_divisor};
      w_ge       = (w_trial >= {1'b0, r_divisor});
      w_next_rem = w_ge ? w_diff[M-1:0] : w_trial[M-1:0];
      w_next_q   = {r_shift_q[M-2:0], w_ge};
   end

`ifdef DIV_SELFCHECK_EN
   logic [N-1:0]   r_dividend;
   logic [N-1:0]   w_prod;
   logic [N-1:0]   w_sum;

   // Keep the original dividend so the finished result can be re-multiplied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dividend <= '0;
      end else if (r_state == ST_IDLE && in_valid && r_in_ready) begin
         r_dividend <= dividend;
      end
   end

   // quotient*divisor + remainder must reconstruct the dividend for normal results.
   always_comb begin
      w_prod    = N'(r_quotient) * N'(r_divisor);
      w_sum     = w_prod + {{(N-M){1'b0}}, r_remainder};
      check_err = (r_state == ST_DONE) && !r_dbz && !r_ovf && (w_sum != r_dividend);
   end
`else
   assign check_err = 1'b0;
`endif

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_divisor   <= '0;
         r_part_rem  <= '0;
         r_shift_q   <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_divisor  <= divisor;
                  r_in_ready <= 1'b0;
                  if (divisor == '0) begin
                     r_dbz       <= 1'b1;
                     r_quotient  <= '1;
                     r_remainder <= dividend[M-1:0];
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else if (dividend[N-1:M] >= divisor) begin
                     r_ovf       <= 1'b1;
                     r_quotient  <= '1;
                     r_remainder <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_part_rem <= dividend[N-1:M];
                     r_shift_q  <= dividend[M-1:0];
                     r_cnt      <= '0;
                     r_state    <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_part_rem <= w_next_rem;
               r_shift_q  <= w_next_q;
               r_cnt      <= r_cnt + 1'b1;
               if (r_cnt == CW'(M-1)) begin
                  r_quotient  <= w_next_q;
                  r_remainder <= w_next_rem;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_dbz       <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_div_seq_64_32.sv
// ---------------------------------------------------------------------------
// tb_div_seq_64_32 : directed and random checks of the sequential divider
// against a plain-arithmetic reference model (64-bit / and %).
// ---------------------------------------------------------------------------
module tb_div_seq_64_32;

   localparam int M = 32;
   localparam int N = 64;
   localparam int NORMAL_LAT = M + 1;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [M-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] quotient;
   logic [M-1:0] remainder;
   logic         div_by_zero;
   logic         overflow;
   logic         check_err;

   int checks;
   int errors;

   // expected {div_by_zero, overflow, quotient, remainder}
   logic [2*M+1:0] exp_q[$];

   div_seq_64_32 #(.M(M), .N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .overflow   (overflow),
      .check_err  (check_err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model: ordinary integer division plus the exception rules
   function automatic logic [2*M+1:0] model(input logic [N-1:0] dvd, input logic [M-1:0] dvs);
      logic [N-1:0] q64;
      logic [N-1:0] r64;
      if (dvs == 0) begin
         return {1'b1, 1'b0, {M{1'b1}}, dvd[M-1:0]};
      end
      q64 = dvd / {32'd0, dvs};
      r64 = dvd % {32'd0, dvs};
      if (q64 > 64'h0000_0000_FFFF_FFFF) begin
         return {1'b0, 1'b1, {M{1'b1}}, {M{1'b0}}};
      end
      return {1'b0, 1'b0, q64[M-1:0], r64[M-1:0]};
   endfunction

   // driver: present operands once in_ready is seen, handshake on next edge
   task automatic start_div(input logic [N-1:0] dvd, input logic [M-1:0] dvs);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      exp_q.push_back(model(dvd, dvs));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
   endtask

   // wait for out_valid; lat = cycle index (handshake cycle is 0)
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic check_result(input string tag, input int lat);
      logic [2*M+1:0] e;
      int exp_lat;
      e = exp_q.pop_front();
      exp_lat = (e[2*M+1] || e[2*M]) ? 1 : NORMAL_LAT;
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_q"},   {32'd0, quotient},  {32'd0, e[2*M-1:M]});
      check({tag, "_r"},   {32'd0, remainder}, {32'd0, e[M-1:0]});
      check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e[2*M+1]});
      check({tag, "_ovf"}, {63'd0, overflow},    {63'd0, e[2*M]});
      check({tag, "_chk"}, {63'd0, check_err},   64'd0);
   endtask

   task automatic accept_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_one(input string tag, input logic [N-1:0] dvd, input logic [M-1:0] dvs);
      int lat;
      start_div(dvd, dvs);
      wait_result(lat);
      check_result(tag, lat);
      accept_result();
   endtask

   initial begin
      int lat;
      logic [M-1:0] hold_q;
      logic [M-1:0] hold_r;
      logic [M-1:0] dvs;
      logic [M-1:0] hi;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  {63'd0, in_ready},    64'd1);
      check("rst_out_valid", {63'd0, out_valid},   64'd0);
      check("rst_q",         {32'd0, quotient},    64'd0);
      check("rst_r",         {32'd0, remainder},   64'd0);
      check("rst_dbz",       {63'd0, div_by_zero}, 64'd0);
      check("rst_ovf",       {63'd0, overflow},    64'd0);
      check("rst_chk",       {63'd0, check_err},   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed cases
      run_one("d100_7", 64'd100, 32'd7);
      run_one("kara_inv", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
      run_one("dbz", 64'h1234_5678_9ABC_DEF0, 32'd0);
      run_one("ovf", 64'h0000_0005_0000_0000, 32'd5);
      run_one("ovf_edge", 64'h0000_0004_FFFF_FFFF, 32'd5);
      run_one("zero_num", 64'd0, 32'd9);
      run_one("div_one", 64'h0000_0000_DEAD_BEEF, 32'd1);

      // random pairs with dividend[63:32] < divisor
      for (int i = 0; i < 1000; i++) begin
         if (i % 4 == 0) dvs = $urandom_range(1, 255);
         else            dvs = $urandom;
         if (dvs == 0) dvs = 1;
         hi = $urandom % dvs;
         run_one("rand", {hi, 32'($urandom)}, dvs);
      end

      // backpressure: result held, second request ignored
      start_div(64'd1000, 32'd3);
      wait_result(lat);
      hold_q = quotient;
      hold_r = remainder;
      check_result("bp", lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = 64'd50;
         divisor  = 32'd5;
         @(posedge clk);
         #1;
         check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         check("bp_in_ready",   {63'd0, in_ready},  64'd0);
         check("bp_hold_q",     {32'd0, quotient},  {32'd0, hold_q});
         check("bp_hold_r",     {32'd0, remainder}, {32'd0, hold_r});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
      check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
      run_one("b2b", 64'h0000_0002_0000_0007, 32'd3);

      // reset during CALC aborts the operation
      start_div(64'h0000_0001_2345_6789, 32'd17);
      void'(exp_q.pop_front());
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_in_ready",  {63'd0, in_ready},  64'd1);
      check("abort_q",         {32'd0, quotient},  64'd0);
      check("abort_r",         {32'd0, remainder}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_one("after_abort", 64'd7, 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_seq_64_32.md
Name: div_seq_64_32

Overview:
- Sequential radix-2 restoring divider: N-bit dividend / M-bit divisor -> M-bit quotient + M-bit remainder.
- Inverse datapath of the 32x32 Karatsuba multiplier (karatsuba_mul_32). Feeding a product C=A*B with divisor B returns quotient A, remainder 0.
- Sits beside the multiplier in the arithmetic unit, behind a valid/ready handshake on both sides; one division in flight at a time.

Parameters:
- M, 32, divisor/quotient/remainder width.
- N, 64, dividend width; must equal 2*M.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  N  numerator, sampled on input handshake
- divisor  input  M  denominator, sampled on input handshake
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  M  quotient
- remainder  output  M  remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in M bits
- check_err  output  1  self-check mismatch (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, check_err=0, counter=0.
- States: IDLE, CALC, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: on in_valid&&in_ready, latch operands.
  - If divisor==0, go to DONE with div_by_zero=1, quotient=all ones, remainder=dividend[M-1:0].
  - Else if dividend[N-1:M] >= divisor, go to DONE with overflow=1, quotient=all ones, remainder=0.
  - Else load partial remainder R=dividend[N-1:M] and shift register Q=dividend[M-1:0], counter=0, then go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - T={R,Q[M-1]} is M+1 bits.
  - If T>=divisor: R=T-divisor and shift 1 into Q LSB.
  - Else: R=T[M-1:0] and shift 0 into Q LSB.
  - Counter increments. After the M-th iteration (counter==M-1), go to DONE with quotient=Q and remainder=R.
- Invariant: R<divisor at all times, so the M+1-bit compare and subtract never overflows.
- Latency: handshake in cycle 0. out_valid rises in cycle M+1 (33 for default) for normal divisions, and in cycle 1 for div_by_zero or overflow.
- DONE: quotient, remainder and flags are held stable while out_valid=1 and out_ready=0. On out_valid&&out_ready, go to IDLE next cycle, clear out_valid and flags. Result data registers keep their values.
- Throughput: one division per M+2 cycles minimum. No overlap; in_valid is ignored outside IDLE.
- Flags are mutually exclusive. div_by_zero has priority when the divisor is 0.
- rst_n asserted mid-CALC or mid-DONE: the operation is aborted, all outputs go to reset values immediately, and the result is lost.
- Inputs dividend/divisor may change freely after the handshake. Only latched copies are used.

Optional Feature:
- Macro DIV_SELFCHECK_EN.
- Defined:
  - In DONE for a normal result, compute quotient*divisor using karatsuba_mul_32, then add {zeros,remainder} using add_64.
  - Compare the sum to the latched dividend. check_err=1 while in DONE if they differ.
  - check_err is held 0 for div_by_zero/overflow results. It is combinational from registered values and adds no latency.
- Undefined: no multiplier or adder instantiated; check_err is tied 0. The port remains present in both builds.

Test Plan:
- dividend=100, divisor=7 -> out_valid exactly 33 cycles after handshake, quotient=14, remainder=2, all flags 0.
- dividend=0xFFFFFFFE00000001, divisor=0xFFFFFFFF -> quotient=0xFFFFFFFF, remainder=0 (Karatsuba inverse case). Also run 1000 random pairs with dividend[63:32]<divisor and check against a reference model, plus check_err=0 when DIV_SELFCHECK_EN is defined.
- divisor=0, dividend=0x123456789ABCDEF0 -> out_valid in cycle 1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x9ABCDEF0. Then dividend=0x0000000500000000, divisor=5 -> overflow=1, quotient=0xFFFFFFFF, remainder=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is ignored. Raise out_ready -> in_ready=1 next cycle, and a back-to-back division completes correctly.
- Deassert rst_n at cycle 10 of CALC -> out_valid=0 and in_ready=1 immediately. After release, a new division 7/7 returns quotient=1, remainder=0 with no residue from the aborted operation.
